// File: rtl/branch_target_buffer_pkg.sv
// BTB geometry, compressed entry types and PC slicing helpers shared by the fetch unit.
// The optional write-first bypass is selected with BTB_WRITE_BYPASS_EN (see branch_target_buffer.sv).
package branch_target_buffer_pkg;

    localparam int BTB_ENTRY_NUM     = 1024;
    localparam int BTB_INDEX_WIDTH   = $clog2(BTB_ENTRY_NUM);
    localparam int BTB_TAG_WIDTH     = 4;
    localparam int BTB_CONTENT_WIDTH = 13;
    localparam int PC_WIDTH          = 32;

    typedef logic [PC_WIDTH-1:0]          PC_Path;
    typedef logic [BTB_INDEX_WIDTH-1:0]   BTBIndex;
    typedef logic [BTB_TAG_WIDTH-1:0]     BTBTag;
    typedef logic [BTB_CONTENT_WIDTH-1:0] BTBContent;

    localparam BTBIndex BTB_INDEX_ONE  = {{(BTB_INDEX_WIDTH-1){1'b0}}, 1'b1};
    localparam BTBIndex BTB_INDEX_LAST = {BTB_INDEX_WIDTH{1'b1}};

    typedef struct packed {
        BTBTag     tag;
        BTBContent data;
    } BTBEntry;

    typedef struct packed {
        logic    valid;
        BTBEntry entry;
    } BTBValidEntry;

    typedef enum logic {
        BTB_PHASE_INIT = 1'b0,
        BTB_PHASE_RUN  = 1'b1
    } BTB_Phase;

    function automatic BTBIndex ToBTB_Index(input PC_Path pc);
        return pc[BTB_INDEX_WIDTH+1:2];
    endfunction

    function automatic BTBTag ToBTB_Tag(input PC_Path pc);
        return pc[BTB_INDEX_WIDTH+BTB_TAG_WIDTH+1:BTB_INDEX_WIDTH+2];
    endfunction

    function automatic BTBContent ToBTB_Content(input PC_Path pc);
        return pc[BTB_CONTENT_WIDTH+1:2];
    endfunction

    // Upper target bits are assumed equal to the fetch PC's; only the low window is stored.
    function automatic PC_Path ToRawAddrFromBTB_PC(input BTBContent content, input PC_Path pc);
        return {pc[PC_WIDTH-1:BTB_CONTENT_WIDTH+2], content, 2'b00};
    endfunction

endpackage

// File: rtl/branch_target_buffer_ram.sv
// Simple dual-port BTB entry RAM: one synchronous read port with hold, one write port.
module btb_ram
    import branch_target_buffer_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    we,
    input  BTBIndex wa,
    input  BTBEntry wd,
    input  logic    re,
    input  BTBIndex ra,
    output BTBEntry rd
);

    BTBEntry entries_q [BTB_ENTRY_NUM];
    BTBEntry rd_q;
    BTBEntry rd_d;

    // Array write port; entries carry no reset, the valid flops in the top gate them.
    always_ff @(posedge clk) begin
        if (we) begin
            entries_q[wa] <= wd;
        end
    end

    // Read data is refreshed only when the lookup stage advances.
    always_comb begin
        if (re) begin
            rd_d = entries_q[ra];
        end else begin
            rd_d = rd_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped fetch-stage BTB with a 1-cycle lookup and a valid-bit clearing sweep after reset.
// Define BTB_WRITE_BYPASS_EN for write-first same-index lookups; the default is read-first.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetchValid,
    input  logic [31:0] fetchPC,
    input  logic        fetchStall,
    output logic        btbReady,
    output logic        btbHit,
    output logic [31:0] btbPredictedPC,
    input  logic        updateEn,
    input  logic [31:0] updatePC,
    input  logic [31:0] updateTarget,
    input  logic        invalidateEn
);

    BTB_Phase                 phase_q, phase_d;
    BTBIndex                  sweep_cnt_q, sweep_cnt_d;
    logic [BTB_ENTRY_NUM-1:0] valid_q, valid_d;
    PC_Path                   reg_pc_q, reg_pc_d;
    logic                     reg_valid_q, reg_valid_d;
    logic                     rd_valid_q, rd_valid_d;

    logic    is_run_s;
    BTBIndex lookup_idx_s;
    BTBIndex upd_idx_s;
    logic    ram_we_s;
    BTBEntry ram_wd_s;
    BTBEntry ram_rd_s;
    BTBEntry lookup_entry_s;
    logic    lookup_valid_s;
    logic    unused_bits_s;

    assign is_run_s     = (phase_q == BTB_PHASE_RUN);
    assign lookup_idx_s = ToBTB_Index(fetchPC);
    assign upd_idx_s    = ToBTB_Index(updatePC);
    assign ram_we_s     = is_run_s & updateEn & ~invalidateEn;
    assign ram_wd_s     = '{tag: ToBTB_Tag(updatePC), data: ToBTB_Content(updateTarget)};

    // Phase sequencing: the sweep visits every index once, then RUN is held until reset.
    always_comb begin
        phase_d     = phase_q;
        sweep_cnt_d = sweep_cnt_q;
        case (phase_q)
            BTB_PHASE_INIT: begin
                sweep_cnt_d = sweep_cnt_q + BTB_INDEX_ONE;
                if (sweep_cnt_q == BTB_INDEX_LAST) begin
                    phase_d = BTB_PHASE_RUN;
                end else begin
                    phase_d = BTB_PHASE_INIT;
                end
            end
            BTB_PHASE_RUN: begin
                phase_d = BTB_PHASE_RUN;
            end
            default: begin
                phase_d     = BTB_PHASE_INIT;
                sweep_cnt_d = '0;
            end
        endcase
    end

    // Phase and sweep counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= BTB_PHASE_INIT;
            sweep_cnt_q <= '0;
        end else begin
            phase_q     <= phase_d;
            sweep_cnt_q <= phase_d == BTB_PHASE_INIT ? sweep_cnt_d : sweep_cnt_q;
        end
    end

    // Valid bits: sweep clear during INIT, then invalidate has priority over update.
    always_comb begin
        valid_d = valid_q;
        if (!is_run_s) begin
            valid_d[sweep_cnt_q] = 1'b0;
        end else if (invalidateEn) begin
            valid_d[upd_idx_s] = 1'b0;
        end else if (updateEn) begin
            valid_d[upd_idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bit storage; the sweep, not the reset, brings it to a known state.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
    end

`ifdef BTB_WRITE_BYPASS_EN
    logic    fwd_sel_s;
    logic    fwd_q, fwd_d;
    BTBEntry fwd_entry_q, fwd_entry_d;

    // Write-first: a same-index write or invalidate is what the lookup sees.
    always_comb begin
        fwd_sel_s      = 1'b0;
        lookup_valid_s = 1'b0;
        if (is_run_s && (updateEn || invalidateEn) && (lookup_idx_s == upd_idx_s)) begin
            fwd_sel_s      = ram_we_s;
            lookup_valid_s = ram_we_s;
        end else begin
            fwd_sel_s      = 1'b0;
            lookup_valid_s = is_run_s & valid_q[lookup_idx_s];
        end
    end

    // Forwarded entry advances together with the rest of the lookup stage.
    always_comb begin
        if (fetchStall) begin
            fwd_d       = fwd_q;
            fwd_entry_d = fwd_entry_q;
        end else begin
            fwd_d       = fwd_sel_s;
            fwd_entry_d = ram_wd_s;
        end
    end

    // Forwarding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q       <= 1'b0;
            fwd_entry_q <= '0;
        end else begin
            fwd_q       <= fwd_d;
            fwd_entry_q <= fwd_entry_d;
        end
    end

    assign lookup_entry_s = fwd_q ? fwd_entry_q : ram_rd_s;
`else
    // Read-first: the lookup samples the valid bit before this cycle's write lands.
    always_comb begin
        lookup_valid_s = is_run_s & valid_q[lookup_idx_s];
    end

    assign lookup_entry_s = ram_rd_s;
`endif

    // Lookup stage capture; a stall freezes the registered request and its result.
    always_comb begin
        if (fetchStall) begin
            reg_pc_d    = reg_pc_q;
            reg_valid_d = reg_valid_q;
            rd_valid_d  = rd_valid_q;
        end else begin
            reg_pc_d    = fetchPC;
            reg_valid_d = fetchValid;
            rd_valid_d  = lookup_valid_s;
        end
    end

    // Lookup stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_pc_q    <= '0;
            reg_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            reg_pc_q    <= reg_pc_d;
            reg_valid_q <= reg_valid_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    btb_ram u_btb_ram (
        .clk (clk),
        .rst (rst),
        .we  (ram_we_s),
        .wa  (upd_idx_s),
        .wd  (ram_wd_s),
        .re  (~fetchStall),
        .ra  (lookup_idx_s),
        .rd  (ram_rd_s)
    );

    assign btbReady       = is_run_s;
    assign btbHit         = reg_valid_q & rd_valid_q & (lookup_entry_s.tag == ToBTB_Tag(reg_pc_q));
    assign btbPredictedPC = ToRawAddrFromBTB_PC(lookup_entry_s.data, reg_pc_q);

    assign unused_bits_s = ^{updatePC[31:16], updatePC[1:0], updateTarget[31:15],
                             updateTarget[1:0], reg_pc_q[11:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (honours BTB_WRITE_BYPASS_EN).
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic        fetchValid;
    logic [31:0] fetchPC;
    logic        fetchStall;
    logic        btbReady;
    logic        btbHit;
    logic [31:0] btbPredictedPC;
    logic        updateEn;
    logic [31:0] updatePC;
    logic [31:0] updateTarget;
    logic        invalidateEn;

    int checks;
    int errors;

    branch_target_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .fetchValid     (fetchValid),
        .fetchPC        (fetchPC),
        .fetchStall     (fetchStall),
        .btbReady       (btbReady),
        .btbHit         (btbHit),
        .btbPredictedPC (btbPredictedPC),
        .updateEn       (updateEn),
        .updatePC       (updatePC),
        .updateTarget   (updateTarget),
        .invalidateEn   (invalidateEn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Releases reset and counts clock edges until btbReady, bounded; also counts INIT hits.
    task automatic run_sweep(output int ready_cycle, output int init_hits, input bit poke_update);
        ready_cycle = -1;
        init_hits   = 0;
        fetchValid  = 1'b1;
        fetchPC     = 32'h0000_1004;
        rst         = 1'b0;
        for (int k = 1; k <= 1100 && ready_cycle < 0; k++) begin
            if (poke_update && k == 10) begin
                updateEn     = 1'b1;
                updatePC     = 32'h0000_1004;
                updateTarget = 32'h0000_2000;
            end else begin
                updateEn = 1'b0;
            end
            step();
            if (btbReady === 1'b1) ready_cycle = k;
            else if (btbHit !== 1'b0) init_hits++;
        end
        updateEn   = 1'b0;
        fetchValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (btbReady !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %0b expected 0", btbReady);
        end
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL reset_hit: got %0b expected 0", btbHit);
        end
        checks++;
        if (btbPredictedPC !== 32'h0) begin
            errors++; $display("FAIL reset_pred: got %08h expected 00000000", btbPredictedPC);
        end
    endtask

    task automatic test_init();
        int ready_cycle;
        int init_hits;
        run_sweep(ready_cycle, init_hits, 1'b1);
        checks++;
        if (init_hits !== 0) begin
            errors++; $display("FAIL init_hit: got %0d hits expected 0", init_hits);
        end
        checks++;
        if (ready_cycle !== 32'd1024) begin
            errors++; $display("FAIL init_ready_cycle: got %0d expected 1024", ready_cycle);
        end
        fetchValid = 1'b1; fetchPC = 32'h0000_1004;
        step();
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL init_update_ignored: got hit %0b expected 0", btbHit);
        end
        fetchValid = 1'b0;
    endtask

    task automatic test_train_hit();
        updateEn = 1'b1; updatePC = 32'h0000_1004; updateTarget = 32'h0000_2000;
        step();
        updateEn = 1'b0;
        fetchValid = 1'b1; fetchPC = 32'h0000_1004;
        step();
        fetchValid = 1'b0;
        checks++;
        if (btbHit !== 1'b1) begin
            errors++; $display("FAIL train_hit: got %0b expected 1", btbHit);
        end
        checks++;
        if (btbPredictedPC !== 32'h0000_2000) begin
            errors++; $display("FAIL train_pred: got %08h expected 00002000", btbPredictedPC);
        end
    endtask

    task automatic test_alias();
        fetchValid = 1'b1; fetchPC = 32'h0000_5004;
        step();
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL alias_miss: got %0b expected 0", btbHit);
        end
        fetchValid = 1'b0;
        updateEn = 1'b1; updatePC = 32'h0000_5004; updateTarget = 32'h0000_3000;
        step();
        updateEn = 1'b0;
        fetchValid = 1'b1; fetchPC = 32'h0000_1004;
        step();
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL overwrite_old_miss: got %0b expected 0", btbHit);
        end
        fetchPC = 32'h0000_5004;
        step();
        fetchValid = 1'b0;
        checks++;
        if (btbHit !== 1'b1 || btbPredictedPC !== 32'h0000_3000) begin
            errors++; $display("FAIL overwrite_new_hit: got hit %0b pc %08h expected hit 1 pc 00003000",
                               btbHit, btbPredictedPC);
        end
    endtask

    task automatic test_invalidate();
        updateEn = 1'b1; invalidateEn = 1'b1;
        updatePC = 32'h0000_1004; updateTarget = 32'h0000_2000;
        step();
        invalidateEn = 1'b0;
        updatePC = 32'h0000_2008; updateTarget = 32'h0000_4000;
        step();
        updateEn = 1'b0;
        fetchValid = 1'b1; fetchPC = 32'h0000_1004;
        step();
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL inval_priority: got %0b expected 0", btbHit);
        end
        fetchPC = 32'h0000_5004;
        step();
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL inval_alias_miss: got %0b expected 0", btbHit);
        end
        fetchValid = 1'b0; fetchPC = 32'h0000_2008;
        step();
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL fetch_valid_low: got %0b expected 0", btbHit);
        end
        fetchValid = 1'b1;
        step();
        fetchValid = 1'b0;
        checks++;
        if (btbHit !== 1'b1 || btbPredictedPC !== 32'h0000_4000) begin
            errors++; $display("FAIL second_entry_hit: got hit %0b pc %08h expected hit 1 pc 00004000",
                               btbHit, btbPredictedPC);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_pc;
        logic        exp_hit;
`ifdef BTB_WRITE_BYPASS_EN
        exp_pc  = 32'h0000_6000;
        exp_hit = 1'b0;
`else
        exp_pc  = 32'h0000_2000;
        exp_hit = 1'b1;
`endif
        updateEn = 1'b1; updatePC = 32'h0000_1004; updateTarget = 32'h0000_2000;
        step();
        updateTarget = 32'h0000_6000;
        fetchValid = 1'b1; fetchPC = 32'h0000_1004;
        step();
        updateEn = 1'b0;
        checks++;
        if (btbHit !== 1'b1 || btbPredictedPC !== exp_pc) begin
            errors++; $display("FAIL bypass_write: got hit %0b pc %08h expected hit 1 pc %08h",
                               btbHit, btbPredictedPC, exp_pc);
        end
        step();
        checks++;
        if (btbHit !== 1'b1 || btbPredictedPC !== 32'h0000_6000) begin
            errors++; $display("FAIL bypass_after_write: got hit %0b pc %08h expected hit 1 pc 00006000",
                               btbHit, btbPredictedPC);
        end
        invalidateEn = 1'b1;
        step();
        invalidateEn = 1'b0;
        checks++;
        if (btbHit !== exp_hit) begin
            errors++; $display("FAIL bypass_invalidate: got %0b expected %0b", btbHit, exp_hit);
        end
        step();
        fetchValid = 1'b0;
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL bypass_after_inval: got %0b expected 0", btbHit);
        end
    endtask

    task automatic test_stall();
        fetchValid = 1'b1; fetchPC = 32'h0000_2008;
        step();
        checks++;
        if (btbHit !== 1'b1 || btbPredictedPC !== 32'h0000_4000) begin
            errors++; $display("FAIL stall_pre_hit: got hit %0b pc %08h expected hit 1 pc 00004000",
                               btbHit, btbPredictedPC);
        end
        fetchStall = 1'b1; fetchPC = 32'h0000_1004;
        updateEn = 1'b1; invalidateEn = 1'b1; updatePC = 32'h0000_2008;
        for (int c = 0; c < 3; c++) begin
            step();
            updateEn = 1'b0; invalidateEn = 1'b0;
            checks++;
            if (btbHit !== 1'b1 || btbPredictedPC !== 32'h0000_4000) begin
                errors++; $display("FAIL stall_hold_%0d: got hit %0b pc %08h expected hit 1 pc 00004000",
                                   c, btbHit, btbPredictedPC);
            end
        end
        fetchStall = 1'b0; fetchPC = 32'h0000_2008;
        step();
        fetchValid = 1'b0;
        checks++;
        if (btbHit !== 1'b0) begin
            errors++; $display("FAIL stall_inval_applied: got %0b expected 0", btbHit);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int ready_cycle;
        int init_hits;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (btbReady !== 1'b0) begin
            errors++; $display("FAIL async_reset_ready: got %0b expected 0", btbReady);
        end
        step();
        rst = 1'b0;
        fetchValid = 1'b1; fetchPC = 32'h0000_2008;
        for (int k = 0; k < 500; k++) step();
        rst = 1'b1;
        step();
        checks++;
        if (btbReady !== 1'b0 || btbHit !== 1'b0 || btbPredictedPC !== 32'h0) begin
            errors++; $display("FAIL mid_sweep_reset: got ready %0b hit %0b pc %08h expected 0 0 00000000",
                               btbReady, btbHit, btbPredictedPC);
        end
        run_sweep(ready_cycle, init_hits, 1'b0);
        checks++;
        if (ready_cycle !== 32'd1024) begin
            errors++; $display("FAIL restart_ready_cycle: got %0d expected 1024", ready_cycle);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        fetchValid   = 1'b0;
        fetchPC      = 32'h0;
        fetchStall   = 1'b0;
        updateEn     = 1'b0;
        updatePC     = 32'h0;
        updateTarget = 32'h0;
        invalidateEn = 1'b0;
        test_reset();
        test_init();
        test_train_hit();
        test_alias();
        test_invalidate();
        test_bypass();
        test_stall();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
